// File: rtl/cordic_angle_seq_if.sv
// Step stream between the CORDIC angle sequencer and the iterative datapath.
// master = sequencer (drives the step), slave = consumer.
interface cordic_angle_seq_if #(
    parameter int WIDTH   = 17,
    parameter int SHIFT_W = 5
);
    logic                      start;
    logic [1:0]                mode;
    logic                      busy;
    logic                      step_valid;
    logic                      step_ready;
    logic [SHIFT_W-1:0]        step_shift;
    logic signed [WIDTH-1:0]   step_angle;
    logic                      step_last;
    logic [5:0]                step_count;

    modport master (
        input  start, mode, step_ready,
        output busy, step_valid, step_shift, step_angle, step_last, step_count
    );

    modport slave (
        output start, mode, step_ready,
        input  busy, step_valid, step_shift, step_angle, step_last, step_count
    );
endinterface

// File: rtl/cordic_angle_seq.sv
// Sequential CORDIC micro-rotation schedule generator: emits (k, angle) per handshake
// for circular / hyperbolic / linear modes, inserting the hyperbolic repeats.
module cordic_angle_seq #(
    parameter int WIDTH   = 17,
    parameter int FRAC    = 13,
    parameter int ITERS   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    cordic_angle_seq_if.master bus
);
    localparam int NK   = 1 << SHIFT_W;
    localparam int KMAX = NK - 1;

    // Angle constants from 124-bit fixed-point Taylor series, then floored to FRAC bits.
    // The circular k=0 entry uses floor(pi/4 * 2^32), so FRAC must not exceed 32.
    function automatic logic [WIDTH-1:0] angle_const(input int m, input int k);
        logic [127:0] acc;
        logic [127:0] term;
        logic [127:0] v;
        logic [127:0] lim;
        acc = '0;
        v   = '0;
        lim = (128'd1 << (WIDTH - 1)) - 128'd1;
        if (k > FRAC || m == 3 || (m == 1 && k == 0)) begin
            v = '0;
        end else if (m == 2) begin
            v = 128'd1 << (FRAC - k);
        end else if (m == 0 && k == 0) begin
            v = 128'd3373259426 >> (32 - FRAC);
        end else begin
            for (int n = 0; n < 64; n++) begin
                if (k * (2 * n + 1) < 124) begin
                    term = (128'd1 << (124 - k * (2 * n + 1))) / 128'(2 * n + 1);
                    if (m == 0 && n[0]) acc = acc - term;
                    else                acc = acc + term;
                end
            end
            v = acc >> (124 - FRAC);
        end
        if (v > lim) v = '0;
        return v[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] w_tbl [4][NK];
    for (genvar gm = 0; gm < 4; gm++) begin : g_mode
        for (genvar gk = 0; gk < NK; gk++) begin : g_k
            localparam logic [WIDTH-1:0] C = angle_const(gm, gk);
            assign w_tbl[gm][gk] = C;
        end
    end

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [6:0]              r_k;
    logic [8:0]              r_rep;
    logic                    r_dup;
    logic [5:0]              r_cnt;
    logic                    r_valid;
    logic                    r_busy;
    logic [SHIFT_W-1:0]      r_shift;
    logic signed [WIDTH-1:0] r_angle;
    logic                    r_last;

    logic                    w_start;
    logic [1:0]              w_mode;
    logic [6:0]              w_k;
    logic [8:0]              w_rep;
    logic                    w_dup;
    logic [5:0]              w_cnt;
    logic [SHIFT_W-1:0]      w_shift;
    logic signed [WIDTH-1:0] w_angle;
    logic                    w_last;

    assign w_start = (r_state == S_IDLE) && bus.start && (bus.mode != 2'b11);

    // Next-step candidate: either the first step of a new run or the step after the current one.
    always_comb begin
        w_mode = r_mode;
        w_k    = r_k;
        w_rep  = r_rep;
        w_dup  = r_dup;
        w_cnt  = r_cnt;
        if (w_start) begin
            w_mode = bus.mode;
            w_k    = (bus.mode == 2'b01) ? 7'd1 : 7'd0;
            w_rep  = 9'd4;
            w_dup  = 1'b0;
            w_cnt  = 6'd0;
        end else if (r_mode == 2'b01 && 9'(r_k) == r_rep && !r_dup) begin
            w_dup = 1'b1;
            w_cnt = r_cnt + 6'd1;
        end else begin
            w_k   = r_k + 7'd1;
            w_cnt = r_cnt + 6'd1;
            if (r_dup) begin
                w_dup = 1'b0;
                w_rep = r_rep + (r_rep << 1) + 9'd1;
            end
        end
        w_shift = (w_k > 7'(KMAX)) ? SHIFT_W'(KMAX) : w_k[SHIFT_W-1:0];
        w_angle = w_tbl[w_mode][w_shift];
        w_last  = (w_cnt == 6'(ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_k     <= '0;
            r_rep   <= '0;
            r_dup   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_angle <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_EMIT;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_mode  <= w_mode;
                        r_k     <= w_k;
                        r_rep   <= w_rep;
                        r_dup   <= w_dup;
                        r_cnt   <= w_cnt;
                        r_shift <= w_shift;
                        r_angle <= w_angle;
                        r_last  <= w_last;
                    end
                end
                S_EMIT: begin
                    if (bus.step_ready) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_k     <= w_k;
                            r_rep   <= w_rep;
                            r_dup   <= w_dup;
                            r_cnt   <= w_cnt;
                            r_shift <= w_shift;
                            r_angle <= w_angle;
                            r_last  <= w_last;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.step_valid = r_valid;
    assign bus.step_shift = r_shift;
    assign bus.step_angle = r_angle;
    assign bus.step_last  = r_last;
    assign bus.step_count = r_cnt;
endmodule

// File: tb/tb_cordic_angle_seq.sv
// Self-checking bench for cordic_angle_seq: ITERS=16 and ITERS=1 instances against a
// reference built from real-valued atan/atanh and the repeat rule k_rep' = 3*k_rep+1.
module tb_cordic_angle_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_angle_seq_if #(.WIDTH(17), .SHIFT_W(5)) a_if ();
    cordic_angle_seq_if #(.WIDTH(17), .SHIFT_W(5)) b_if ();

    cordic_angle_seq #(.WIDTH(17), .FRAC(13), .ITERS(16), .SHIFT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.master));
    cordic_angle_seq #(.WIDTH(17), .FRAC(13), .ITERS(1), .SHIFT_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.master));

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {int k; int ang; int cnt; bit last;} step_t;
    step_t obs[$];
    int    exp_k[$];
    int    unstable;
    bit    timed_out, v_first, b_first, v_after, b_after;

    function automatic int ref_angle(int m, int k);
        real x;
        if (k > 13) return 0;
        x = 1.0 / (2.0 ** k);
        case (m)
            0: return int'($floor($atan(x) * 8192.0));
            1: return (k == 0) ? 0 : int'($floor($atanh(x) * 8192.0));
            default: return 8192 >> k;
        endcase
    endfunction

    function automatic void ref_sched(int m, int n);
        int k, rep;
        exp_k.delete();
        k = (m == 1) ? 1 : 0;
        rep = 4;
        while (exp_k.size() < n) begin
            exp_k.push_back(k);
            if (m == 1 && k == rep && exp_k.size() < n) begin
                exp_k.push_back(k);
                rep = 3 * rep + 1;
            end
            k++;
        end
    endfunction

    // Runs one transaction on dut_a and records every handshake; rpat: 0 ready high, 1 toggle, 2 random.
    task automatic collect(input int m, input int rpat, input bit noise);
        int pk, pa, pcnt;
        bit pl, pv, rdy, fire, fin;
        obs.delete();
        unstable = 0;
        timed_out = 1'b1;
        v_after = 1'b1;
        b_after = 1'b1;
        a_if.mode = 2'(m);
        a_if.start = 1'b1;
        a_if.step_ready = 1'b0;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        v_first = a_if.step_valid;
        b_first = a_if.busy;
        for (int c = 0; c < 200; c++) begin
            case (rpat)
                0: rdy = 1'b1;
                1: rdy = (c % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            a_if.step_ready = rdy;
            if (noise) begin
                a_if.start = 1'($urandom_range(0, 1));
                a_if.mode = 2'($urandom_range(0, 3));
            end
            pk = int'(a_if.step_shift);
            pa = int'(a_if.step_angle);
            pcnt = int'(a_if.step_count);
            pl = a_if.step_last;
            pv = a_if.step_valid;
            fire = pv && rdy;
            fin = fire && pl;
            if (fire) obs.push_back('{pk, pa, pcnt, pl});
            @(posedge clk); #1;
            if (noise) a_if.start = 1'b0;
            if (pv && !fire && (pk != int'(a_if.step_shift) || pa != int'(a_if.step_angle) ||
                pcnt != int'(a_if.step_count) || pl != a_if.step_last || !a_if.step_valid))
                unstable++;
            if (fin) begin
                timed_out = 1'b0;
                v_after = a_if.step_valid;
                b_after = a_if.busy;
                break;
            end
        end
        a_if.step_ready = 1'b0;
        a_if.start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({a_if.step_valid, a_if.busy, a_if.step_last} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v/b/l=%b%b%b want 000", a_if.step_valid, a_if.busy, a_if.step_last);
        end
        n_cmp++;
        if ({a_if.step_shift, a_if.step_angle, a_if.step_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got k=%0d ang=%0d cnt=%0d want 0", a_if.step_shift, a_if.step_angle, a_if.step_count);
        end
        n_cmp++;
        if ({b_if.step_valid, b_if.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_b: got v/b=%b%b want 00", b_if.step_valid, b_if.busy);
        end
    endtask

    task automatic test_circular();
        int circ_ref[4] = '{6433, 3798, 2006, 1018};
        collect(0, 0, 1'b0);
        ref_sched(0, 16);
        n_cmp++;
        if ({v_first, b_first} !== 2'b11) begin
            n_fail++;
            $display("FAIL circ_latency: got v/b=%b%b want 11", v_first, b_first);
        end
        n_cmp++;
        if (obs.size() != 16 || timed_out) begin
            n_fail++;
            $display("FAIL circ_count: got %0d steps timeout=%0d want 16", obs.size(), timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs[i].k != exp_k[i] || obs[i].ang != ref_angle(0, exp_k[i]) ||
                obs[i].cnt != i || obs[i].last != (i == 15)) begin
                n_fail++;
                $display("FAIL circ_step%0d: got k=%0d ang=%0d cnt=%0d last=%0d want k=%0d ang=%0d",
                         i, obs[i].k, obs[i].ang, obs[i].cnt, obs[i].last, exp_k[i], ref_angle(0, exp_k[i]));
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs[i].ang != circ_ref[i]) begin
                n_fail++;
                $display("FAIL circ_const%0d: got %0d want %0d", i, obs[i].ang, circ_ref[i]);
            end
        end
        n_cmp++;
        if ({v_after, b_after} !== 2'b00) begin
            n_fail++;
            $display("FAIL circ_end: got v/b=%b%b want 00", v_after, b_after);
        end
    endtask

    task automatic test_hyperbolic();
        int hk[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
        collect(1, 2, 1'b0);
        ref_sched(1, 16);
        n_cmp++;
        if (obs.size() != 16 || timed_out || unstable != 0) begin
            n_fail++;
            $display("FAIL hyp_count: got %0d steps unstable=%0d timeout=%0d want 16/0/0", obs.size(), unstable, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs[i].k != hk[i] || obs[i].k != exp_k[i] || obs[i].ang != ref_angle(1, exp_k[i]) ||
                obs[i].cnt != i || obs[i].last != (i == 15)) begin
                n_fail++;
                $display("FAIL hyp_step%0d: got k=%0d ang=%0d cnt=%0d last=%0d want k=%0d ang=%0d",
                         i, obs[i].k, obs[i].ang, obs[i].cnt, obs[i].last, hk[i], ref_angle(1, exp_k[i]));
            end
        end
        n_cmp++;
        if (obs[0].ang != 4499 || obs[1].ang != 2092 || obs[3].ang != 512 ||
            obs[13].ang != 1 || obs[15].ang != 0) begin
            n_fail++;
            $display("FAIL hyp_const: got %0d %0d %0d %0d %0d want 4499 2092 512 1 0",
                     obs[0].ang, obs[1].ang, obs[3].ang, obs[13].ang, obs[15].ang);
        end
    endtask

    task automatic test_linear();
        collect(2, 1, 1'b0);
        n_cmp++;
        if (obs.size() != 16 || timed_out || unstable != 0) begin
            n_fail++;
            $display("FAIL lin_count: got %0d steps unstable=%0d timeout=%0d want 16/0/0", obs.size(), unstable, timed_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs[i].k != i || obs[i].ang != ref_angle(2, i) || obs[i].cnt != i) begin
                n_fail++;
                $display("FAIL lin_step%0d: got k=%0d ang=%0d cnt=%0d want k=%0d ang=%0d",
                         i, obs[i].k, obs[i].ang, obs[i].cnt, i, ref_angle(2, i));
            end
        end
    endtask

    task automatic test_start_ignored();
        a_if.mode = 2'b11;
        a_if.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_if.start = 1'b0;
        n_cmp++;
        if ({a_if.step_valid, a_if.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reserved_mode: got v/b=%b%b want 00", a_if.step_valid, a_if.busy);
        end
        collect(0, 2, 1'b1);
        ref_sched(0, 16);
        n_cmp++;
        if (obs.size() != 16 || timed_out || unstable != 0 || {v_after, b_after} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_start: got %0d steps unstable=%0d end v/b=%b%b want 16/0/00",
                     obs.size(), unstable, v_after, b_after);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs[i].k != exp_k[i] || obs[i].ang != ref_angle(0, exp_k[i]) || obs[i].cnt != i) begin
                n_fail++;
                $display("FAIL busy_start_step%0d: got k=%0d ang=%0d want k=%0d ang=%0d",
                         i, obs[i].k, obs[i].ang, exp_k[i], ref_angle(0, exp_k[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        a_if.mode = 2'b00;
        a_if.start = 1'b1;
        a_if.step_ready = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_if.step_count !== 6'd3) begin
            n_fail++;
            $display("FAIL mid_count: got %0d want 3", a_if.step_count);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_if.step_ready = 1'b0;
        test_reset();
        @(posedge clk); #1;
        n_cmp++;
        if ({a_if.step_valid, a_if.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_abandon: got v/b=%b%b want 00", a_if.step_valid, a_if.busy);
        end
        collect(0, 0, 1'b0);
        n_cmp++;
        if (obs.size() != 16 || obs[0].cnt != 0 || obs[0].k != 0 || obs[15].cnt != 15) begin
            n_fail++;
            $display("FAIL mid_restart: got %0d steps first cnt=%0d k=%0d want 16 steps from 0",
                     obs.size(), obs[0].cnt, obs[0].k);
        end
    endtask

    task automatic test_iters1();
        for (int m = 0; m < 2; m++) begin
            b_if.mode = 2'(m);
            b_if.start = 1'b1;
            b_if.step_ready = 1'b1;
            @(posedge clk); #1;
            b_if.start = 1'b0;
            n_cmp++;
            if (b_if.step_valid !== 1'b1 || b_if.step_last !== 1'b1 || int'(b_if.step_shift) != m ||
                int'(b_if.step_angle) != ref_angle(m, m) || b_if.step_count !== 6'd0) begin
                n_fail++;
                $display("FAIL iters1_m%0d: got v=%b l=%b k=%0d ang=%0d want v=1 l=1 k=%0d ang=%0d",
                         m, b_if.step_valid, b_if.step_last, b_if.step_shift, b_if.step_angle, m, ref_angle(m, m));
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({b_if.step_valid, b_if.busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL iters1_end_m%0d: got v/b=%b%b want 00", m, b_if.step_valid, b_if.busy);
            end
        end
        b_if.step_ready = 1'b0;
    endtask

    task automatic test_random();
        int m;
        for (int r = 0; r < 4; r++) begin
            m = $urandom_range(0, 2);
            collect(m, 2, 1'b0);
            ref_sched(m, 16);
            n_cmp++;
            if (obs.size() != 16 || timed_out || unstable != 0) begin
                n_fail++;
                $display("FAIL rand%0d_count: mode=%0d got %0d steps unstable=%0d want 16/0", r, m, obs.size(), unstable);
            end
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (obs[i].k != exp_k[i] || obs[i].ang != ref_angle(m, exp_k[i]) || obs[i].last != (i == 15)) begin
                    n_fail++;
                    $display("FAIL rand%0d_step%0d: mode=%0d got k=%0d ang=%0d want k=%0d ang=%0d",
                             r, i, m, obs[i].k, obs[i].ang, exp_k[i], ref_angle(m, exp_k[i]));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.start = 1'b0; a_if.mode = 2'b00; a_if.step_ready = 1'b0;
        b_if.start = 1'b0; b_if.mode = 2'b00; b_if.step_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_circular();
        test_hyperbolic();
        test_linear();
        test_start_ignored();
        test_reset_mid();
        test_iters1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_angle_seq.md
Name: cordic_angle_seq

Overview:
- Parametrised, sequential successor to the fixed hyperbolic angle ROM.
- On a start request, emits the complete CORDIC micro-rotation schedule, one step per accepted handshake. Each step carries a shift index k and the angle constant for the selected mode: circular, hyperbolic or linear.
- Inserts the hyperbolic convergence repeats.
- Feeds the iterative CORDIC datapath used by the tanh/sigmoid activation units of the MLP.

Parameters:
- WIDTH, 17: angle word width, signed two's complement.
- FRAC, 13: fractional bits of the angle word.
- ITERS, 16: number of steps emitted per run, including repeats; range 1..63.
- SHIFT_W, 5: width of the shift index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- mode  in  2  00 circular, 01 hyperbolic, 10 linear, 11 reserved; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until the last step is accepted
- step_valid  out  1  step outputs valid
- step_ready  in  1  consumer accepts the step
- step_shift  out  SHIFT_W  shift index k
- step_angle  out  WIDTH  angle constant for k
- step_last  out  1  marks the final step of the run
- step_count  out  6  0-based step number within the run

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. busy, step_valid, step_last = 0. step_shift, step_angle, step_count = 0. Any run in progress is abandoned; no further steps are emitted.
- States: IDLE, EMIT.
- IDLE -> EMIT when start=1 and mode!=11.
  - The next cycle presents step 0 with step_valid=1 and busy=1. Latency start->first valid is 1 cycle.
  - start with mode=11 is ignored.
- EMIT, step_valid=1 and step_ready=0: all step outputs hold stable.
- EMIT, step_valid=1 and step_ready=1:
  - If step_last=1: next cycle state=IDLE and step_valid=busy=0.
  - Otherwise the next step appears on the next cycle. Zero-bubble throughput with step_ready held high is 1 step/cycle.
- start is ignored while busy, including in the same cycle the last step is accepted. A new run requires start in IDLE.
- Shift schedule:
  - Circular and linear: k = 0,1,2,... (k = step_count).
  - Hyperbolic: k starts at 1 and each of k = 4, 13, 40 (k_rep_next = 3*k_rep+1) is emitted twice, consecutively. This gives 1,2,3,4,4,5,...,13,13,14,...
  - ITERS counts emitted steps, so repeats consume the step budget.
- step_last = 1 exactly when step_count = ITERS-1.
- Angle constants, truncated (floor) to FRAC fractional bits:
  - Circular: floor(atan(2^-k) * 2^FRAC).
  - Hyperbolic: floor(atanh(2^-k) * 2^FRAC).
  - Linear: 2^FRAC >> k.
  - If k > FRAC, or the constant does not fit WIDTH, step_angle = 0.
- Tables may be constant case logic or computed at elaboration. The output must be registered; no combinational path from mode/start to step outputs.
- mode changes during EMIT have no effect on the run in progress.
- step_shift saturates at 2^SHIFT_W-1. The angle for that k is 0 by the rule above.

Test Plan:
- Reset mid-run: start circular, accept 3 steps, assert rst_n=0 for 1 cycle -> next cycle step_valid=0, busy=0, all outputs 0. A subsequent start restarts at step_count=0.
- Circular, ITERS=16, step_ready=1:
  - start -> valid 1 cycle later.
  - Angles (k0..k3) = 6433, 3798, 2006, 1018.
  - step_last on step_count=15 (k=15).
  - busy low the cycle after acceptance.
- Hyperbolic, ITERS=16:
  - shifts = 1,2,3,4,4,5,...,13,13,14.
  - Angles at k=1,2,4,13 = 4499, 2092, 512, 1.
  - The last step has k=14, angle 0.
- Linear with backpressure: toggle step_ready 1/0 each cycle -> angles 8192, 4096, 2048, ... each held stable while ready=0; exactly 16 handshakes; no skips or duplicates.
- start pulsed while busy, and with mode=11 in IDLE -> ignored; step sequence and busy unaffected.
- ITERS=1: start -> a single step with step_last=1, k=0 (circular) or k=1 (hyperbolic); IDLE after acceptance.
